// File: rtl/axi_stream_pkg.sv
// ---------------------------------------------------------------------------
// axi_stream_pkg
// Shared AXI-Stream widths, the parsed Add Order record and ITCH constants
// used by the Add Order transmitter. Also holds the transmitter FSM states.
// ---------------------------------------------------------------------------
package axi_stream_pkg;

  localparam int AXIS_DATA_WIDTH = 64;
  localparam int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8;

  // ITCH message type byte and message geometry
  localparam logic [7:0] ITCH_ADD_ORDER     = 8'h41;
  localparam int         ITCH_ADD_ORDER_LEN = 36;
  localparam logic [7:0] ITCH_SIDE_BUY      = 8'h42;
  localparam logic [7:0] ITCH_SIDE_SELL     = 8'h53;

  // Order fields as delivered by the upstream parser
  typedef struct packed {
    logic        valid;
    logic [47:0] timestamp;
    logic [63:0] order_ref;
    logic        side;       // 1 = sell, 0 = buy
    logic [31:0] shares;
    logic [63:0] stock;
    logic [31:0] price;
  } parsed_add_order_t;

  // Transmitter states: idle plus one state per 64-bit output beat
  typedef enum logic [2:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1,
    S_BEAT2,
    S_BEAT3,
    S_BEAT4
  } tx_state_e;

endpackage

// File: rtl/itch_add_order_tx_if.sv
// ---------------------------------------------------------------------------
// itch_add_order_tx_if
// AXI-Stream bundle carrying the encoded ITCH byte stream.
//   tdata  : 64-bit beat, byte 0 on [63:56]
//   tkeep  : byte enables, bit 7 = byte 0
//   tvalid : beat present
//   tlast  : final beat of a message
//   tready : sink accepts the beat
// master = transmitter side, slave = sink side.
// ---------------------------------------------------------------------------
interface itch_add_order_tx_if;
  import axi_stream_pkg::*;

  logic [AXIS_DATA_WIDTH-1:0] tdata;
  logic [AXIS_KEEP_WIDTH-1:0] tkeep;
  logic                       tvalid;
  logic                       tlast;
  logic                       tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);

endinterface

// File: rtl/itch_add_order_tx.sv
// ---------------------------------------------------------------------------
// itch_add_order_tx
// Encodes parsed orders into 36-byte big-endian ITCH Add Order messages and
// streams them as five 64-bit AXI-Stream beats.
//
// Parameter:
//   TRACK_INIT   : tracking number used for the first message after reset
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : order_in/stock_locate hold an order to send
//   in_ready     : order is accepted this cycle when in_valid is high
//   order_in     : order fields (order_in.valid is ignored)
//   stock_locate : locate code captured with the order
//   m_axis       : AXI-Stream master (tdata/tkeep/tvalid/tlast/tready)
//   tx_count     : number of messages fully transmitted (wraps)
//   busy         : a message is held or in flight
//
// Build option:
//   ITCH_TX_LEN_PREFIX_EN : prepend the 2-byte length 16'h0024 so each
//   message is 38 stream bytes; last beat keeps 6 bytes instead of 4.
// ---------------------------------------------------------------------------
module itch_add_order_tx
  import axi_stream_pkg::*;
#(
  parameter logic [15:0] TRACK_INIT = 16'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  parsed_add_order_t   order_in,
  input  logic [15:0]         stock_locate,
  itch_add_order_tx_if.master m_axis,
  output logic [63:0]         tx_count,
  output logic                busy
);

  localparam int MSG_BITS    = ITCH_ADD_ORDER_LEN * 8;
  localparam int STREAM_BITS = 5 * AXIS_DATA_WIDTH;

`ifdef ITCH_TX_LEN_PREFIX_EN
  localparam logic [AXIS_KEEP_WIDTH-1:0] LAST_KEEP = 8'hFC;
`else
  localparam logic [AXIS_KEEP_WIDTH-1:0] LAST_KEEP = 8'hF0;
`endif

  tx_state_e                  state_q, state_d;
  parsed_add_order_t          order_q, order_d;
  logic [15:0]                locate_q, locate_d;
  logic [15:0]                track_hold_q, track_hold_d;
  logic [15:0]                tracking_q, tracking_d;
  logic [63:0]                tx_count_q, tx_count_d;
  logic                       tvalid_q, tvalid_d;
  logic                       tlast_q, tlast_d;
  logic [AXIS_KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic [AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                       accept;
  logic                       beat_done;

  // The whole message is laid out as one padded 320-bit stream and the
  // beat state just selects which 64-bit slice goes out.
  function automatic logic [AXIS_DATA_WIDTH-1:0] format_beat(
    input tx_state_e         st,
    input parsed_add_order_t ord,
    input logic [15:0]       loc,
    input logic [15:0]       trk
  );
    logic [MSG_BITS-1:0]        msg;
    logic [STREAM_BITS-1:0]     stream;
    logic [AXIS_DATA_WIDTH-1:0] beat;
    msg = {ITCH_ADD_ORDER, loc, trk, ord.timestamp, ord.order_ref,
           (ord.side ? ITCH_SIDE_SELL : ITCH_SIDE_BUY),
           ord.shares, ord.stock, ord.price};
`ifdef ITCH_TX_LEN_PREFIX_EN
    stream = {16'(ITCH_ADD_ORDER_LEN), msg, 16'h0000};
`else
    stream = {msg, 32'h0000_0000};
`endif
    case (st)
      S_BEAT0: beat = stream[STREAM_BITS-1                     -: AXIS_DATA_WIDTH];
      S_BEAT1: beat = stream[STREAM_BITS-1-AXIS_DATA_WIDTH     -: AXIS_DATA_WIDTH];
      S_BEAT2: beat = stream[STREAM_BITS-1-2*AXIS_DATA_WIDTH   -: AXIS_DATA_WIDTH];
      S_BEAT3: beat = stream[STREAM_BITS-1-3*AXIS_DATA_WIDTH   -: AXIS_DATA_WIDTH];
      S_BEAT4: beat = stream[STREAM_BITS-1-4*AXIS_DATA_WIDTH   -: AXIS_DATA_WIDTH];
      default: beat = '0;
    endcase
    return beat;
  endfunction

  // Accepting during the last beat's handshake lets messages run back to
  // back with no idle cycle between them.
  assign in_ready  = (state_q == S_IDLE) || (state_q == S_BEAT4 && m_axis.tready);
  assign accept    = in_valid && in_ready;
  assign beat_done = tvalid_q && m_axis.tready;

  always_comb begin
    state_d      = state_q;
    order_d      = order_q;
    locate_d     = locate_q;
    track_hold_d = track_hold_q;
    tracking_d   = tracking_q;
    tx_count_d   = tx_count_q;

    case (state_q)
      S_IDLE:  if (accept)    state_d = S_BEAT0;
      S_BEAT0: if (beat_done) state_d = S_BEAT1;
      S_BEAT1: if (beat_done) state_d = S_BEAT2;
      S_BEAT2: if (beat_done) state_d = S_BEAT3;
      S_BEAT3: if (beat_done) state_d = S_BEAT4;
      S_BEAT4: begin
        if (beat_done) begin
          tracking_d = tracking_q + 16'd1;
          tx_count_d = tx_count_q + 64'd1;
          state_d    = accept ? S_BEAT0 : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Capture the post-increment tracking value so a back-to-back order
    // gets the next number even though it is accepted on the same edge.
    if (accept) begin
      order_d      = order_in;
      locate_d     = stock_locate;
      track_hold_d = tracking_d;
    end

    // Outputs are computed from the next state so they leave a flop.
    tvalid_d = (state_d != S_IDLE);
    tlast_d  = (state_d == S_BEAT4);
    tkeep_d  = '0;
    tdata_d  = '0;
    if (tvalid_d) begin
      tkeep_d = tlast_d ? LAST_KEEP : {AXIS_KEEP_WIDTH{1'b1}};
      tdata_d = format_beat(state_d, order_d, locate_d, track_hold_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      order_q      <= '0;
      locate_q     <= '0;
      track_hold_q <= '0;
      tracking_q   <= TRACK_INIT;
      tx_count_q   <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tkeep_q      <= '0;
      tdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      order_q      <= order_d;
      locate_q     <= locate_d;
      track_hold_q <= track_hold_d;
      tracking_q   <= tracking_d;
      tx_count_q   <= tx_count_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tkeep_q      <= tkeep_d;
      tdata_q      <= tdata_d;
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tkeep  = tkeep_q;
  assign m_axis.tdata  = tdata_q;
  assign tx_count      = tx_count_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_itch_add_order_tx.sv
// ---------------------------------------------------------------------------
// tb_itch_add_order_tx
// Directed bench for itch_add_order_tx. Two instances share all inputs:
// dut0 uses TRACK_INIT = 0, dut1 uses TRACK_INIT = 16'hFFFF so tracking
// wrap can be observed. Expected beats are hand-encoded constants for the
// reference order (ref 1, 100 shares, "AAPL    ", price 1500000,
// ts 0x010203040506, locate 7), for both the bare and length-prefixed build.
// ---------------------------------------------------------------------------
module tb_itch_add_order_tx;
  import axi_stream_pkg::*;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              tready;
  parsed_add_order_t order_in;
  logic [15:0]       stock_locate;
  logic              in_ready0, in_ready1;
  logic              busy0, busy1;
  logic [63:0]       tx_count0, tx_count1;

  int checks = 0;
  int errors = 0;

  logic [63:0] cap0_data[$];
  logic [7:0]  cap0_keep[$];
  logic        cap0_last[$];
  logic [63:0] cap1_data[$];
  logic [7:0]  cap1_keep[$];

  itch_add_order_tx_if m0();
  itch_add_order_tx_if m1();

  assign m0.tready = tready;
  assign m1.tready = tready;

  itch_add_order_tx #(.TRACK_INIT(16'd0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .order_in(order_in), .stock_locate(stock_locate), .m_axis(m0),
    .tx_count(tx_count0), .busy(busy0)
  );

  itch_add_order_tx #(.TRACK_INIT(16'hFFFF)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .order_in(order_in), .stock_locate(stock_locate), .m_axis(m1),
    .tx_count(tx_count1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every beat that completes a handshake; inputs only change just
  // after posedge, so the negedge view matches what the next edge takes.
  always @(negedge clk) begin
    if (!rst && m0.tvalid && m0.tready) begin
      cap0_data.push_back(m0.tdata);
      cap0_keep.push_back(m0.tkeep);
      cap0_last.push_back(m0.tlast);
    end
    if (!rst && m1.tvalid && m1.tready) begin
      cap1_data.push_back(m1.tdata);
      cap1_keep.push_back(m1.tkeep);
    end
  end

`ifdef ITCH_TX_LEN_PREFIX_EN
  localparam logic [7:0] EXP_LAST_KEEP = 8'hFC;
`else
  localparam logic [7:0] EXP_LAST_KEEP = 8'hF0;
`endif

  // Hand-encoded beats of the reference order for a given tracking/side
  function automatic logic [63:0] exp_beat(input int idx, input logic [15:0] trk, input bit sell);
    logic [7:0] sb;
    sb = sell ? 8'h53 : 8'h42;
`ifdef ITCH_TX_LEN_PREFIX_EN
    case (idx)
      0:       return {40'h00_24_41_00_07, trk, 8'h01};
      1:       return 64'h02_03_04_05_06_00_00_00;
      2:       return {40'h00_00_00_00_01, sb, 16'h0000};
      3:       return 64'h00_64_41_41_50_4C_20_20;
      default: return 64'h20_20_00_16_E3_60_00_00;
    endcase
`else
    case (idx)
      0:       return {24'h41_00_07, trk, 24'h01_02_03};
      1:       return 64'h04_05_06_00_00_00_00_00;
      2:       return {24'h00_00_01, sb, 32'h00_00_00_64};
      3:       return 64'h41_41_50_4C_20_20_20_20;
      default: return 64'h00_16_E3_60_00_00_00_00;
    endcase
`endif
  endfunction

  function automatic parsed_add_order_t make_order(input bit sell, input bit vld);
    parsed_add_order_t o;
    o.valid     = vld;
    o.timestamp = 48'h0102_0304_0506;
    o.order_ref = 64'h1;
    o.side      = sell;
    o.shares    = 32'd100;
    o.stock     = 64'h4141_504C_2020_2020;
    o.price     = 32'd1500000;
    return o;
  endfunction

  task automatic clear_caps();
    cap0_data.delete(); cap0_keep.delete(); cap0_last.delete();
    cap1_data.delete(); cap1_keep.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_caps();
  endtask

  // Present an order and hold it until it is accepted (bounded)
  task automatic offer(input parsed_add_order_t o);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    order_in = o; stock_locate = 16'd7; in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready0) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1 in_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL offer_accept: in_ready never high, required 1"); end
  endtask

  task automatic wait_beats(input int which, input int n);
    int got;
    for (int k = 0; k < 100; k++) begin
      got = (which == 0) ? cap0_data.size() : cap1_data.size();
      if (got >= n) break;
      @(negedge clk);
    end
    got = (which == 0) ? cap0_data.size() : cap1_data.size();
    checks++;
    if (got < n) begin errors++; $display("[TB] FAIL wait_beats%0d: got %0d beats, required %0d", which, got, n); end
  endtask

  // Check the five captured dut0 beats of one reference message
  task automatic check_msg0(input string tag, input int base, input logic [15:0] trk, input bit sell);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cap0_data[base+i] !== exp_beat(i, trk, sell)) begin
        errors++;
        $display("[TB] FAIL %s_data%0d: got %h required %h", tag, i, cap0_data[base+i], exp_beat(i, trk, sell));
      end
      checks++;
      if (cap0_keep[base+i] !== ((i == 4) ? EXP_LAST_KEEP : 8'hFF) || cap0_last[base+i] !== (i == 4)) begin
        errors++;
        $display("[TB] FAIL %s_keeplast%0d: got keep %h last %b", tag, i, cap0_keep[base+i], cap0_last[base+i]);
      end
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0; tready = 1'b1; rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (m0.tvalid !== 1'b0 || m0.tlast !== 1'b0 || m0.tkeep !== 8'h00 || m0.tdata !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_axis: got v=%b l=%b k=%h d=%h, required all zero", m0.tvalid, m0.tlast, m0.tkeep, m0.tdata);
    end
    checks++;
    if (tx_count0 !== 64'd0 || busy0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_count_busy: got count %0d busy %b, required 0/0", tx_count0, busy0);
    end
    @(posedge clk); #1 rst = 1'b0;
    clear_caps();
    @(negedge clk);
    checks++;
    if (in_ready0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready0); end
    repeat (3) @(negedge clk);
    checks++;
    if (m0.tvalid !== 1'b0 || cap0_data.size() != 0) begin
      errors++;
      $display("[TB] FAIL idle_no_beats: got tvalid %b beats %0d, required 0/0", m0.tvalid, cap0_data.size());
    end
  endtask

  task automatic test_single();
    clear_caps();
    tready = 1'b1;
    offer(make_order(1'b0, 1'b1));
    wait_beats(0, 5);
    repeat (3) @(negedge clk);
    checks++;
    if (cap0_data.size() != 5) begin errors++; $display("[TB] FAIL single_beats: got %0d required 5", cap0_data.size()); end
    else check_msg0("single", 0, 16'h0000, 1'b0);
    checks++;
    if (tx_count0 !== 64'd1 || busy0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_count: got count %0d busy %b, required 1/0", tx_count0, busy0);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    tready = 1'b1;
    order_in = make_order(1'b0, 1'b1); stock_locate = 16'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    order_in = make_order(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (m0.tvalid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_tvalid%0d: got %b required 1", i, m0.tvalid); end
      if (i == 4) begin
        checks++;
        if (in_ready0 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready: got %b required 1", in_ready0); end
        @(posedge clk); #1 in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (m0.tvalid !== 1'b0 || cap0_data.size() != 10) begin
      errors++;
      $display("[TB] FAIL b2b_end: got tvalid %b beats %0d, required 0/10", m0.tvalid, cap0_data.size());
    end else begin
      check_msg0("b2b_first", 0, 16'h0000, 1'b0);
      check_msg0("b2b_second", 5, 16'h0001, 1'b1);
    end
    checks++;
    if (tx_count0 !== 64'd2) begin errors++; $display("[TB] FAIL b2b_count: got %0d required 2", tx_count0); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    tready = 1'b1;
    order_in = make_order(1'b0, 1'b1); stock_locate = 16'd7; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (m0.tvalid !== 1'b1 || m0.tdata !== exp_beat(2, 16'h0000, 1'b0)) begin
        errors++;
        $display("[TB] FAIL stall_data%0d: got v=%b %h required %h", k, m0.tvalid, m0.tdata, exp_beat(2, 16'h0000, 1'b0));
      end
      checks++;
      if (in_ready0 !== 1'b0 || busy0 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_ready%0d: got in_ready %b busy %b, required 0/1", k, in_ready0, busy0);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (cap0_data.size() != 2) begin errors++; $display("[TB] FAIL stall_beats: got %0d required 2", cap0_data.size()); end
    tready = 1'b1;
    wait_beats(0, 5);
    repeat (2) @(negedge clk);
    checks++;
    if (cap0_data.size() != 5) begin errors++; $display("[TB] FAIL stall_total: got %0d required 5", cap0_data.size()); end
    else check_msg0("stall", 0, 16'h0000, 1'b0);
    checks++;
    if (tx_count0 !== 64'd1) begin errors++; $display("[TB] FAIL stall_count: got %0d required 1", tx_count0); end
  endtask

  task automatic test_reset_mid();
    clear_caps();
    tready = 1'b1;
    @(posedge clk); #1;
    order_in = make_order(1'b0, 1'b1); stock_locate = 16'd7; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (m0.tvalid !== 1'b0 || m0.tdata !== 64'h0 || m0.tkeep !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midrst_axis: got v=%b k=%h d=%h, required zero", m0.tvalid, m0.tkeep, m0.tdata);
    end
    checks++;
    if (tx_count0 !== 64'd0 || busy0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_count: got count %0d busy %b, required 0/0", tx_count0, busy0);
    end
    checks++;
    if (cap0_data.size() != 3) begin errors++; $display("[TB] FAIL midrst_partial: got %0d beats required 3", cap0_data.size()); end
    @(posedge clk); #1 rst = 1'b0;
    clear_caps();
    @(negedge clk);
    checks++;
    if (in_ready0 !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready: got %b required 1", in_ready0); end
    offer(make_order(1'b0, 1'b1));
    wait_beats(0, 5);
    repeat (2) @(negedge clk);
    checks++;
    if (cap0_data.size() != 5) begin errors++; $display("[TB] FAIL midrst_total: got %0d required 5", cap0_data.size()); end
    else check_msg0("midrst", 0, 16'h0000, 1'b0);
    checks++;
    if (tx_count0 !== 64'd1) begin errors++; $display("[TB] FAIL midrst_count2: got %0d required 1", tx_count0); end
  endtask

  task automatic test_track_wrap();
    apply_reset();
    tready = 1'b1;
    offer(make_order(1'b0, 1'b1));
    wait_beats(1, 5);
    offer(make_order(1'b1, 1'b1));
    wait_beats(1, 10);
    repeat (2) @(negedge clk);
    checks++;
    if (cap1_data.size() != 10) begin
      errors++;
      $display("[TB] FAIL wrap_beats: got %0d required 10", cap1_data.size());
    end else begin
      checks++;
      if (cap1_data[0] !== exp_beat(0, 16'hFFFF, 1'b0)) begin
        errors++;
        $display("[TB] FAIL wrap_first: got %h required %h", cap1_data[0], exp_beat(0, 16'hFFFF, 1'b0));
      end
      checks++;
      if (cap1_data[5] !== exp_beat(0, 16'h0000, 1'b1)) begin
        errors++;
        $display("[TB] FAIL wrap_second: got %h required %h", cap1_data[5], exp_beat(0, 16'h0000, 1'b1));
      end
      checks++;
      if (cap1_data[7] !== exp_beat(2, 16'h0000, 1'b1) || cap1_keep[9] !== EXP_LAST_KEEP) begin
        errors++;
        $display("[TB] FAIL wrap_sell: got %h keep %h", cap1_data[7], cap1_keep[9]);
      end
    end
    checks++;
    if (tx_count1 !== 64'd2) begin errors++; $display("[TB] FAIL wrap_count: got %0d required 2", tx_count1); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; tready = 1'b1;
    order_in = '0; stock_locate = 16'd0;
    $display("[TB] starting itch_add_order_tx bench");
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_track_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/itch_add_order_tx.md
ITCH_ADD_ORDER_TX -- requirements
Module: itch_add_order_tx

Interface
REQ-001 SHALL have parameter: TRACK_INIT, 16'd0, tracking number used for the first message after reset.
REQ-002 SHALL have port: clk  input  1  sole clock; all logic on posedge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  order_in holds an order to send.
REQ-005 SHALL have port: in_ready  output  1  block accepts order_in this cycle.
REQ-006 SHALL have port: order_in  input  parsed_add_order_t  order fields; order_in.valid ignored.
REQ-007 SHALL have port: stock_locate  input  16  locate code, sampled with order_in.
REQ-008 SHALL have ports: m_axis_tdata  output  64 (byte 0 = [63:56]); m_axis_tkeep  output  8; m_axis_tvalid  output  1; m_axis_tlast  output  1; m_axis_tready  input  1.
REQ-009 SHALL have port: tx_count  output  64  messages fully transmitted.
REQ-010 SHALL have port: busy  output  1  high while a message is held or in flight.

Function
REQ-011 SHALL encode each accepted order as a 36-byte ITCH Add Order, big-endian: type 0x41, locate, tracking, timestamp[47:0], order_ref, side, shares, stock, price, at offsets 0/1/3/5/11/19/20/24/32.
REQ-012 SHALL emit side byte 0x53 ('S') when order_in.side=1, else 0x42 ('B').
REQ-013 SHALL use FSM states S_IDLE, S_BEAT0..S_BEAT4; acceptance moves S_IDLE->S_BEAT0; each beat advances only on m_axis_tvalid && m_axis_tready.
REQ-014 SHALL capture order_in, stock_locate and the current tracking number into holding registers on acceptance (in_valid && in_ready).
REQ-015 SHALL drive in_ready = (state==S_IDLE) || (state==S_BEAT4 && m_axis_tready).
REQ-016 SHALL, on acceptance during S_BEAT4 handshake, go directly to S_BEAT0 (back-to-back, 5 cycles per message at full rate).
REQ-017 SHALL assert m_axis_tvalid in every S_BEATn state, registered; first beat appears the cycle after acceptance.
REQ-018 SHALL hold tdata/tkeep/tlast stable while tvalid && !tready; tvalid never drops mid-message except on reset.
REQ-019 SHALL drive tkeep=8'hFF, tlast=0 on beats 0-3; tkeep=8'hF0, tlast=1, bytes 4-7 zero on beat 4 (no prefix).
REQ-020 SHALL increment tracking (16-bit, wraps 16'hFFFF->16'h0000) and tx_count (64-bit, wraps) on the beat-4 handshake.
REQ-021 SHALL drive busy = (state != S_IDLE).
REQ-022 SHALL not accept input when in_valid is low; S_IDLE with no input produces no beats.

Reset
REQ-023 SHALL, while rst=1, force state S_IDLE, m_axis_tvalid=0, tlast=0, tkeep=0, tdata=0, tx_count=0, tracking=TRACK_INIT, busy=0; in_ready=1 in the cycle after rst deasserts.
REQ-024 SHALL abandon a partially sent message on rst (no completion, tx_count not incremented); tvalid low in the cycle after rst sampled high.

Configuration
REQ-025 SHALL, with ITCH_TX_LEN_PREFIX_EN defined, prepend the 2-byte big-endian length 16'h0024 (38 stream bytes): message byte k at stream byte k+2; beat 4 tkeep=8'hFC, bytes 6-7 zero.
REQ-026 SHALL, without ITCH_TX_LEN_PREFIX_EN, emit the bare 36-byte message per REQ-019; beat count is 5 in both cases.

Structure
REQ-027 SHALL take AXIS_DATA_WIDTH, AXIS_KEEP_WIDTH, ITCH_ADD_ORDER, parsed_add_order_t from axi_stream_pkg; add ITCH_ADD_ORDER_LEN (36), ITCH_SIDE_BUY (0x42), ITCH_SIDE_SELL (0x53) there.
REQ-028 SHALL be a single module; no sub-module; beat formatting is a local function of beat index and holding registers.

Verification
REQ-029 Single order (ref 64'h1, side 0, shares 100, stock "AAPL    ", price 1500000, ts 48'h0102_0304_0506, locate 7), tready=1 -> beat0 = 41 00 07 00 00 01 02 03, 5 beats, beat4 tkeep F0, tx_count=1.
REQ-030 Two orders back-to-back, in_valid held -> 10 consecutive tvalid beats, no gap, tracking 0 then 1.
REQ-031 tready low 3 cycles during beat 2 -> beat 2 data stable all 3 cycles, in_ready=0, message completes intact.
REQ-032 TRACK_INIT=16'hFFFF, two orders -> tracking fields FFFF then 0000.
REQ-033 rst asserted during beat 3 -> next cycle tvalid=0, tx_count=0; following order emits full message with tracking=TRACK_INIT.
REQ-034 With ITCH_TX_LEN_PREFIX_EN, order from REQ-029 -> beat0 = 00 24 41 00 07 00 00 01, beat4 tkeep FC, tlast=1.
